branch_hazard_scoreboard: RTL and testbench

BRANCH_HAZARD_SCOREBOARD -- requirements
Module: branch_hazard_scoreboard

---
 rtl/branch_hazard_scoreboard_pkg.sv | 20 ++
 rtl/branch_hazard_scoreboard_hazard_match.sv | 22 ++
 rtl/branch_hazard_scoreboard.sv | 94 +++++++++
 tb/tb_branch_hazard_scoreboard.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/branch_hazard_scoreboard_pkg.sv
// Shared core package: pipe tracking entry and register address sizing.
// The forwarding controllers use the same entry type, so the address field
// is sized for the widest register file in the core (ENTRY_ADDR_W). Narrower
// register addresses are zero-extended into it.
package branch_hazard_scoreboard_pkg;

  localparam int REG_WIDTH_DEFAULT = 5;
  localparam int ENTRY_ADDR_W      = 8;
  localparam int NUM_STAGES        = 3;   // index 0 = EX, 1 = MEM, 2 = WB
  localparam int NUM_OPERANDS      = 2;   // index 0 = RS1, 1 = RS2

  typedef struct packed {
    logic                    valid;
    logic [ENTRY_ADDR_W-1:0] addr;
    logic                    is_load;
  } pipe_entry_t;

  localparam pipe_entry_t BUBBLE = '0;

endpackage

// File: rtl/branch_hazard_scoreboard_hazard_match.sv
// hazard_match: compares one ID source operand against one tracked entry.
//   entry        : tracked producer (valid/addr/is_load)
//   operand      : ID source register address (zero-extended)
//   operand_used : the instruction actually reads this operand
//   match        : operand depends on this entry's result
//   match_load   : match and the producer is a load
module hazard_match
  import branch_hazard_scoreboard_pkg::*;
(
  input  pipe_entry_t             entry,
  input  logic [ENTRY_ADDR_W-1:0] operand,
  input  logic                    operand_used,
  output logic                    match,
  output logic                    match_load
);

  // x0 is hardwired zero, so it never carries a dependency.
  assign match      = operand_used && entry.valid && (operand != '0) &&
                      (entry.addr == operand);
  assign match_load = match && entry.is_load;

endmodule

// File: rtl/branch_hazard_scoreboard.sv
// branch_hazard_scoreboard: tracks destination registers in EX/MEM/WB and
// raises a stall for the ID instruction when forwarding cannot cover it.
//   i_Clock, i_Reset (async, active-high)
//   i_Hold           : freeze all state
//   i_Flush          : ID instruction is squashed into a bubble
//   i_Inst*          : ID instruction sources, destination and kind
//   o_Stall          : hold PC and IF/ID, bubble into ID/EX
//   o_StallCount     : saturating count of stall cycles
module branch_hazard_scoreboard
  import branch_hazard_scoreboard_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEFAULT
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Hold,
  input  logic                 i_Flush,
  input  logic                 i_InstValid,
  input  logic [REG_WIDTH-1:0] i_InstRS1,
  input  logic [REG_WIDTH-1:0] i_InstRS2,
  input  logic                 i_InstUsesRS2,
  input  logic                 i_InstIsBranch,
  input  logic [REG_WIDTH-1:0] i_InstRegWrAddr,
  input  logic                 i_InstRegWrEnable,
  input  logic                 i_InstIsLoad,
  output logic                 o_Stall,
  output logic [31:0]          o_StallCount
);

  pipe_entry_t [NUM_STAGES-1:0]                     pipe_q;
  pipe_entry_t                                      id_entry;
  logic [NUM_OPERANDS-1:0][ENTRY_ADDR_W-1:0]        op_addr;
  logic [NUM_OPERANDS-1:0]                          op_used;
  logic [NUM_STAGES-1:0][NUM_OPERANDS-1:0]          match;
  logic [NUM_STAGES-1:0][NUM_OPERANDS-1:0]          match_load;
  logic                                             issue;
  logic [ENTRY_ADDR_W-1:0]                          wr_addr;

  assign op_addr[0] = ENTRY_ADDR_W'(i_InstRS1);
  assign op_addr[1] = ENTRY_ADDR_W'(i_InstRS2);
  assign op_used[0] = 1'b1;
  assign op_used[1] = i_InstUsesRS2;
  assign wr_addr    = ENTRY_ADDR_W'(i_InstRegWrAddr);

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    for (genvar o = 0; o < NUM_OPERANDS; o++) begin : g_op
      hazard_match u_match (
        .entry        (pipe_q[s]),
        .operand      (op_addr[o]),
        .operand_used (op_used[o]),
        .match        (match[s][o]),
        .match_load   (match_load[s][o])
      );
    end
  end

  // MEM non-load and WB hits are resolved by forwarding, so they never stall.
  logic unused_fwd_hits;
  assign unused_fwd_hits = ^{match[1], match[2], match_load[2]};

  // Branches compare in ID, so they need results one stage earlier than
  // ALU operands do: any EX producer, or a load still in MEM, blocks them.
  always_comb begin
    o_Stall = 1'b0;
    if (i_InstValid && !i_Flush) begin
      if (i_InstIsBranch) o_Stall = (|match[0]) || (|match_load[1]);
      else                o_Stall = |match_load[0];
    end
  end

  assign issue = i_InstValid && !o_Stall && !i_Flush;

  always_comb begin
    id_entry = BUBBLE;
    if (issue && i_InstRegWrEnable && (wr_addr != '0)) begin
      id_entry.valid   = 1'b1;
      id_entry.addr    = wr_addr;
      id_entry.is_load = i_InstIsLoad;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      pipe_q       <= '0;
      o_StallCount <= '0;
    end else if (!i_Hold) begin
      pipe_q[0] <= id_entry;
      pipe_q[1] <= pipe_q[0];
      pipe_q[2] <= pipe_q[1];
      if (o_Stall && (o_StallCount != '1)) o_StallCount <= o_StallCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_hazard_scoreboard.sv
module tb_branch_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold, flush, valid, uses2, branch, wr_en, is_load;
  logic [4:0]  rs1, rs2, rd;
  logic        stall;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;
  logic exp_q[$];

  branch_hazard_scoreboard #(.REG_WIDTH(5)) dut (
    .i_Clock           (clk),
    .i_Reset           (rst),
    .i_Hold            (hold),
    .i_Flush           (flush),
    .i_InstValid       (valid),
    .i_InstRS1         (rs1),
    .i_InstRS2         (rs2),
    .i_InstUsesRS2     (uses2),
    .i_InstIsBranch    (branch),
    .i_InstRegWrAddr   (rd),
    .i_InstRegWrEnable (wr_en),
    .i_InstIsLoad      (is_load),
    .o_Stall           (stall),
    .o_StallCount      (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one ID instruction for one cycle; expected stall goes through the queue.
  task automatic step(input string tag, input logic v, input logic br,
                      input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                      input logic [4:0] d, input logic we, input logic ld,
                      input logic fl, input logic hd, input logic exp_stall);
    logic e;
    valid = v; branch = br; rs1 = r1; rs2 = r2; uses2 = u2;
    rd = d; wr_en = we; is_load = ld; flush = fl; hold = hd;
    exp_q.push_back(exp_stall);
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, {31'd0, stall}, {31'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; branch = 0; rs1 = 0; rs2 = 0; uses2 = 0;
    rd = 0; wr_en = 0; is_load = 0; flush = 0; hold = 0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    check({tag, "_rst_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_rst_cnt"}, stall_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #12;
    do_reset("init");

    // add x5 then beq x5,x6: one stall cycle
    step("alu_add",  1,0, 1,2,1, 5,1,0, 0,0, 0);
    step("alu_beq0", 1,1, 5,6,1, 0,0,0, 0,0, 1);
    step("alu_beq1", 1,1, 5,6,1, 0,0,0, 0,0, 0);
    step("alu_idle", 0,0, 0,0,0, 0,0,0, 0,0, 0);
    check("alu_cnt", stall_count, 32'd1);

    // lw x7 then beq x7,x0: two stall cycles
    do_reset("s2");
    step("ld_lw",    1,0, 1,0,0, 7,1,1, 0,0, 0);
    step("ld_beq0",  1,1, 7,0,1, 0,0,0, 0,0, 1);
    step("ld_beq1",  1,1, 7,0,1, 0,0,0, 0,0, 1);
    step("ld_beq2",  1,1, 7,0,1, 0,0,0, 0,0, 0);
    check("ld_cnt", stall_count, 32'd2);

    // lw x7 then add x8,x7,x1: load-use, one cycle
    do_reset("s3");
    step("lu_lw",    1,0, 1,0,0, 7,1,1, 0,0, 0);
    step("lu_add0",  1,0, 7,1,1, 8,1,0, 0,0, 1);
    step("lu_add1",  1,0, 7,1,1, 8,1,0, 0,0, 0);
    check("lu_cnt", stall_count, 32'd1);

    // lw x7 then sub x8,x1,x2 (no use); then RS2 not read
    do_reset("s3b");
    step("nu_lw",    1,0, 1,0,0, 7,1,1, 0,0, 0);
    step("nu_sub",   1,0, 1,2,1, 8,1,0, 0,0, 0);
    step("nu_lw2",   1,0, 1,0,0, 9,1,1, 0,0, 0);
    step("nu_rs2off",1,0, 1,9,0, 8,1,0, 0,0, 0);
    step("nu_alu5",  1,0, 1,0,0, 5,1,0, 0,0, 0);
    step("nu_addx5", 1,0, 5,5,1, 6,1,0, 0,0, 0);
    check("nu_cnt", stall_count, 32'd0);

    // add x0 then beq x0,x0: never tracked
    do_reset("s4");
    step("x0_add",   1,0, 1,2,1, 0,1,0, 0,0, 0);
    step("x0_beq",   1,1, 0,0,1, 0,0,0, 0,0, 0);

    // lw x9 then beq x1,x9 via RS2
    do_reset("s4b");
    step("r2_lw",    1,0, 1,0,0, 9,1,1, 0,0, 0);
    step("r2_beq0",  1,1, 1,9,1, 0,0,0, 0,0, 1);
    step("r2_beq1",  1,1, 1,9,1, 0,0,0, 0,0, 1);
    step("r2_beq2",  1,1, 1,9,1, 0,0,0, 0,0, 0);
    check("r2_cnt", stall_count, 32'd2);

    // flush wins over stall; load then sits in MEM
    do_reset("s4c");
    step("fl_lw",    1,0, 1,0,0, 7,1,1, 0,0, 0);
    step("fl_beq",   1,1, 7,0,1, 0,0,0, 1,0, 0);
    step("fl_beqm",  1,1, 7,0,1, 0,0,0, 0,0, 1);
    step("fl_beqw",  1,1, 7,0,1, 0,0,0, 0,0, 0);
    check("fl_cnt", stall_count, 32'd1);

    // hold for 3 cycles in the middle of a load->branch stall
    do_reset("s5");
    step("hd_lw",    1,0, 1,0,0, 7,1,1, 0,0, 0);
    step("hd_beq0",  1,1, 7,0,1, 0,0,0, 0,0, 1);
    for (int i = 0; i < 3; i++) begin
      step("hd_held", 1,1, 7,0,1, 0,0,0, 0,1, 1);
      check("hd_cnt_frozen", stall_count, 32'd1);
    end
    step("hd_beq1",  1,1, 7,0,1, 0,0,0, 0,0, 1);
    step("hd_beq2",  1,1, 7,0,1, 0,0,0, 0,0, 0);
    check("hd_cnt", stall_count, 32'd2);

    // reset pulsed mid-stall
    do_reset("s6");
    step("rs_lw",    1,0, 1,0,0, 7,1,1, 0,0, 0);
    step("rs_beq0",  1,1, 7,0,1, 0,0,0, 0,0, 1);
    @(negedge clk);
    check("rs_pre", {31'd0, stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rs_async_stall", {31'd0, stall}, 32'd0);
    check("rs_async_cnt", stall_count, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step("rs_after", 1,1, 7,0,1, 0,0,0, 0,0, 0);
    step("rs_after2",1,1, 7,0,1, 0,0,0, 0,0, 0);
    check("rs_cnt", stall_count, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
